// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register (pipe_stage_buf).
package pipe_pkg;

    localparam int DEPTH_MAX = 4;
    localparam int NCH_MAX   = 8;
    localparam int CNT_W     = 16;

    // Total packed width of all channels carried by one stage.
    function automatic int packed_width(input int nch, input int width);
        return nch * width;
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: a valid flag plus DW bits of packed channel data.
// clear_i wins over load_i; with neither asserted the stage holds.
// A stage loaded with an invalid word stores all-zero data.
module pipe_stage_cell #(
    parameter int DW = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    // Next-state selection: clear, load (with bubble zeroing) or hold.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = valid_i ? data_i : '0;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the data field is reset too, so a bubble never exposes stale or X data downstream.
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register: NCH channels of WIDTH bits
// through DEPTH stages, with stall (hold) and flush (bubble) controls.
// Optional macro PIPE_STATS_EN adds saturating stall/flush event counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 3,
    parameter int DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [NCH*WIDTH-1:0]   data_i,
    output logic                   valid_o,
    output logic [NCH*WIDTH-1:0]   data_o
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
`endif
);

    localparam int DW = packed_width(NCH, WIDTH);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH must be in 1..%0d", DEPTH_MAX);
    end
    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("pipe_stage_buf: NCH must be in 1..%0d", NCH_MAX);
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("pipe_stage_buf: WIDTH must be in 1..64");
    end

    // Flush clears every stage; otherwise every stage shifts unless stalled.
    logic stage_clear;
    logic stage_load;

    assign stage_clear = flush_i;
    assign stage_load  = !stall_i;

    logic          stage_valid [DEPTH];
    logic [DW-1:0] stage_data  [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          cell_valid_in;
        logic [DW-1:0] cell_data_in;

        if (k == 0) begin : g_head
            assign cell_valid_in = valid_i;
            assign cell_data_in  = data_i;
        end else begin : g_link
            assign cell_valid_in = stage_valid[k-1];
            assign cell_data_in  = stage_data[k-1];
        end

        pipe_stage_cell #(
            .DW (DW)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .load_i  (stage_load),
            .clear_i (stage_clear),
            .valid_i (cell_valid_in),
            .data_i  (cell_data_in),
            .valid_o (stage_valid[k]),
            .data_o  (stage_data[k])
        );
    end

    assign valid_o = stage_valid[DEPTH-1];
    assign data_o  = stage_data[DEPTH-1];

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; a flush masks a simultaneous stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_i) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall_i) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance
// share the same inputs. Directed table, hand sequences, then random
// stimulus against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int WIDTH = 32;
    localparam int NCH   = 3;
    localparam int DW    = WIDTH * NCH;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i;
    logic          flush_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          valid2_o, valid4_o;
    logic [DW-1:0] data2_o,  data4_o;
`ifdef PIPE_STATS_EN
    logic [15:0]   stall2_cnt, flush2_cnt, stall4_cnt, flush4_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .valid_o (valid2_o),
        .data_o  (data2_o)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt_o (stall2_cnt),
        .flush_cnt_o (flush2_cnt)
`endif
    );

    pipe_stage_buf #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .valid_o (valid4_o),
        .data_o  (data4_o)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt_o (stall4_cnt),
        .flush_cnt_o (flush4_cnt)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: inputs were set at a negedge, outputs sampled at the next negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic v, input logic [DW-1:0] d);
        rst = r; stall_i = s; flush_i = f; valid_i = v; data_i = d;
    endtask

    typedef struct {
        logic          rst;
        logic          stall;
        logic          flush;
        logic          vin;
        logic [DW-1:0] din;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic v,
                                input logic [DW-1:0] d, input logic ev, input logic [DW-1:0] ed);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.vin = v; t.din = d; t.ev = ev; t.ed = ed;
        return t;
    endfunction

    localparam logic [DW-1:0] ABC  = {32'hC, 32'hB, 32'hA};
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] W1 = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001};
    localparam logic [DW-1:0] W2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
    localparam logic [DW-1:0] W3 = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
    localparam logic [DW-1:0] W4 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001};
    localparam logic [DW-1:0] W5 = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
    localparam logic [DW-1:0] W6 = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001};

    // Reference model: each pipe is a queue of words, newest at the front.
    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } word_t;

    word_t m2[$];
    word_t m4[$];
    int    m_stall_cnt, m_flush_cnt;

    function automatic void model_clear(ref word_t q[$], input int depth);
        word_t z;
        z.v = 1'b0; z.d = '0;
        q.delete();
        for (int i = 0; i < depth; i++) q.push_back(z);
    endfunction

    function automatic void model_edge(ref word_t q[$], input int depth, input logic r,
                                       input logic s, input logic f, input logic v,
                                       input logic [DW-1:0] d);
        word_t w;
        if (r || f) begin
            model_clear(q, depth);
        end else if (!s) begin
            w.v = v;
            w.d = v ? d : '0;
            q.push_front(w);
            void'(q.pop_back());
        end
    endfunction

    function automatic void model_cnt(input logic r, input logic s, input logic f);
        if (r) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else if (f) begin
            if (m_flush_cnt < 65535) m_flush_cnt++;
        end else if (s) begin
            if (m_stall_cnt < 65535) m_stall_cnt++;
        end
    endfunction

    vec_t tbl [17];

    initial begin
        // Directed vectors for the DEPTH=2 instance; expected output after each edge.
        tbl[0]  = mk(1, 0, 0, 0, '0,   0, '0);  // reset
        tbl[1]  = mk(1, 0, 0, 0, '0,   0, '0);
        tbl[2]  = mk(0, 0, 0, 1, ABC,  0, '0);  // first word enters stage 0
        tbl[3]  = mk(0, 0, 0, 0, ONES, 1, ABC); // visible two cycles later; bubble with junk data
        tbl[4]  = mk(0, 0, 0, 0, '0,   0, '0);  // bubble arrives as zeros
        tbl[5]  = mk(0, 0, 0, 1, W1,   0, '0);
        tbl[6]  = mk(0, 0, 0, 1, W2,   1, W1);
        tbl[7]  = mk(0, 1, 0, 1, W3,   1, W1);  // stall x3: output frozen
        tbl[8]  = mk(0, 1, 0, 1, W3,   1, W1);
        tbl[9]  = mk(0, 1, 0, 1, W3,   1, W1);
        tbl[10] = mk(0, 0, 0, 1, W3,   1, W2);
        tbl[11] = mk(0, 0, 0, 0, '0,   1, W3);
        tbl[12] = mk(0, 0, 0, 0, '0,   0, '0);
        tbl[13] = mk(0, 0, 0, 1, W4,   0, '0);
        tbl[14] = mk(0, 0, 0, 1, W5,   1, W4);  // pipe full
        tbl[15] = mk(0, 1, 1, 1, W6,   0, '0);  // flush beats stall
        tbl[16] = mk(0, 0, 0, 0, '0,   0, '0);  // stage 0 was cleared too

        drive(1, 0, 0, 0, '0);
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].vin, tbl[i].din);
            step();
            check($sformatf("tbl[%0d] valid_o", i), {127'b0, valid2_o}, {127'b0, tbl[i].ev});
            check($sformatf("tbl[%0d] data_o", i), {32'b0, data2_o}, {32'b0, tbl[i].ed});
`ifdef PIPE_STATS_EN
            if (i == 14) begin
                check("stall_cnt after 3 stalls", {112'b0, stall2_cnt}, 128'd3);
                check("flush_cnt before flush", {112'b0, flush2_cnt}, 128'd0);
            end
            if (i == 15) begin
                check("stall_cnt unchanged by flush+stall", {112'b0, stall2_cnt}, 128'd3);
                check("flush_cnt after flush", {112'b0, flush2_cnt}, 128'd1);
            end
`endif
        end

        // Mid-operation reset on the DEPTH=4 instance.
        drive(0, 0, 0, 1, W1); step();
        drive(0, 0, 0, 1, W2); step();
        drive(0, 0, 0, 1, W3); step();
        drive(0, 0, 0, 1, W4); step();
        check("d4 full valid_o", {127'b0, valid4_o}, 128'd1);
        check("d4 full data_o", {32'b0, data4_o}, {32'b0, W1});
        drive(1, 0, 0, 1, W5); step();
        check("d4 reset valid_o", {127'b0, valid4_o}, 128'd0);
        check("d4 reset data_o", {32'b0, data4_o}, 128'd0);
        drive(0, 0, 0, 1, W6); step();
        drive(0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d4 post-reset empty %0d", i), {127'b0, valid4_o}, 128'd0);
            step();
        end
        check("d4 new word valid_o", {127'b0, valid4_o}, 128'd1);
        check("d4 new word data_o", {32'b0, data4_o}, {32'b0, W6});

        // Randomized run against the queue model; starts with a reset to align state.
        drive(1, 0, 0, 0, '0);
        step();
        model_clear(m2, 2);
        model_clear(m4, 4);
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            logic r, s, f, v;
            logic [DW-1:0] d;
            r = ($urandom_range(63) == 0);
            f = ($urandom_range(15) == 0);
            s = ($urandom_range(3) == 0);
            v = $urandom_range(1);
            d = {$urandom, $urandom, $urandom};
            drive(r, s, f, v, d);
            step();
            model_edge(m2, 2, r, s, f, v, d);
            model_edge(m4, 4, r, s, f, v, d);
            model_cnt(r, s, f);
            check("rand d2 valid_o", {127'b0, valid2_o}, {127'b0, m2[1].v});
            check("rand d2 data_o", {32'b0, data2_o}, {32'b0, m2[1].d});
            check("rand d4 valid_o", {127'b0, valid4_o}, {127'b0, m4[3].v});
            check("rand d4 data_o", {32'b0, data4_o}, {32'b0, m4[3].d});
`ifdef PIPE_STATS_EN
            check("rand stall_cnt", {112'b0, stall4_cnt}, 128'(m_stall_cnt));
            check("rand flush_cnt", {112'b0, flush4_cnt}, 128'(m_flush_cnt));
`endif
        end

`ifdef PIPE_STATS_EN
        // Stall counter saturation.
        drive(1, 0, 0, 0, '0); step();
        drive(0, 1, 0, 1, W1);
        for (int n = 0; n < 70000; n++) @(posedge clk);
        @(negedge clk);
        check("stall_cnt saturated", {112'b0, stall2_cnt}, 128'hFFFF);
        check("flush_cnt idle during stall", {112'b0, flush2_cnt}, 128'd0);
        for (int n = 0; n < 5; n++) step();
        check("stall_cnt stays saturated", {112'b0, stall2_cnt}, 128'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
